// File: rtl/bsh_pkg.sv
// Shared mode encodings and sizing helper for the pipelined barrel shifter.
package bsh_pkg;

  localparam logic [1:0] BSH_SLL = 2'b00;
  localparam logic [1:0] BSH_SRL = 2'b01;
  localparam logic [1:0] BSH_SRA = 2'b10;
  localparam logic [1:0] BSH_ROR = 2'b11;

  function automatic int bshShamtW(input int dataW);
    return $clog2(dataW);
  endfunction

endpackage

// File: rtl/bsh_stage.sv
// One log2 stage of the barrel shifter: conditional shift by STEP plus a valid/ready register slice.
// Status flags exist only when BARREL_SHIFTER_FLAG_EN is defined; the first stage (STEP==1) derives them.
module bsh_stage
  import bsh_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [1:0]         i_mode,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_data,
  output logic [1:0]         o_mode,
  output logic [SHAMT_W-1:0] o_shamt
`ifdef BARREL_SHIFTER_FLAG_EN
  ,
  input  logic               i_zero,
  input  logic               i_cout,
  output logic               o_zero,
  output logic               o_cout
`endif
);

  localparam int K = $clog2(STEP);

  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [1:0]         r_mode;
  logic [SHAMT_W-1:0] r_shamt;
  logic [DATA_W-1:0]  w_shifted;
  logic [DATA_W-1:0]  w_next;

  always_comb begin
    w_shifted = i_data;
    case (i_mode)
      BSH_SLL: w_shifted = i_data << STEP;
      BSH_SRL: w_shifted = i_data >> STEP;
      BSH_SRA: w_shifted = {{STEP{i_data[DATA_W-1]}}, i_data[DATA_W-1:STEP]};
      default: w_shifted = {i_data[STEP-1:0], i_data[DATA_W-1:STEP]};
    endcase
    w_next = i_shamt[K] ? w_shifted : i_data;
  end

  // Empty slots always accept, so bubbles collapse toward the output.
  assign o_ready = !r_valid || i_ready;

`ifdef BARREL_SHIFTER_FLAG_EN
  logic r_zero;
  logic r_cout;
  logic w_zero;
  logic w_cout;

  if (STEP == 1) begin : gFlagCalc
    logic [DATA_W-1:0]  w_full;
    logic [DATA_W-1:0]  w_rotLo;
    logic [SHAMT_W-1:0] w_idx;
    logic               w_unusedCarry;

    assign w_unusedCarry = i_zero ^ i_cout;

    // Full-width result only feeds the zero flag; the data path stays staged.
    always_comb begin
      w_rotLo = DATA_W'({i_data, i_data} >> i_shamt);
      case (i_mode)
        BSH_SLL: w_full = i_data << i_shamt;
        BSH_SRL: w_full = i_data >> i_shamt;
        BSH_SRA: w_full = $signed(i_data) >>> i_shamt;
        default: w_full = w_rotLo;
      endcase
      w_idx  = (i_mode == BSH_SLL) ? -i_shamt : i_shamt - SHAMT_W'(1);
      w_zero = (w_full == '0);
      w_cout = (i_shamt != '0) && i_data[w_idx];
    end
  end else begin : gFlagCarry
    assign w_zero = i_zero;
    assign w_cout = i_cout;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_zero <= 1'b0;
      r_cout <= 1'b0;
    end else if (o_ready && i_valid) begin
      r_zero <= w_zero;
      r_cout <= w_cout;
    end
  end

  assign o_zero = r_zero;
  assign o_cout = r_cout;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= '0;
      r_shamt <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data  <= w_next;
        r_mode  <= i_mode;
        r_shamt <= i_shamt;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_mode  = r_mode;
  assign o_shamt = r_shamt;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined SLL/SRL/SRA/ROR barrel shifter: one bsh_stage per shift-amount bit, valid/ready on both ends.
// Define BARREL_SHIFTER_FLAG_EN to add the o_zero/o_cout status outputs.
module barrel_shifter_pipe
  import bsh_pkg::*;
#(
  parameter  int DATA_W  = 32,
  localparam int SHAMT_W = bshShamtW(DATA_W)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [1:0]         i_mode,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [DATA_W-1:0]  o_data
`ifdef BARREL_SHIFTER_FLAG_EN
  ,
  output logic               o_zero,
  output logic               o_cout
`endif
);

  logic               w_valid [SHAMT_W+1];
  logic               w_ready [SHAMT_W+1];
  logic [DATA_W-1:0]  w_data  [SHAMT_W+1];
  logic [1:0]         w_mode  [SHAMT_W+1];
  logic [SHAMT_W-1:0] w_shamt [SHAMT_W+1];
  logic [SHAMT_W+1:0] w_unusedTail;

  assign w_valid[0]       = i_valid;
  assign w_data[0]        = i_data;
  assign w_mode[0]        = i_mode;
  assign w_shamt[0]       = i_shamt;
  assign w_ready[SHAMT_W] = i_ready;
  assign o_ready          = w_ready[0];
  assign o_valid          = w_valid[SHAMT_W];
  assign o_data           = w_data[SHAMT_W];

  // Mode and shift amount are not needed once the last stage has applied its shift.
  assign w_unusedTail = {w_mode[SHAMT_W], w_shamt[SHAMT_W]};

`ifdef BARREL_SHIFTER_FLAG_EN
  logic w_zero [SHAMT_W+1];
  logic w_cout [SHAMT_W+1];

  assign w_zero[0] = 1'b0;
  assign w_cout[0] = 1'b0;
  assign o_zero    = w_zero[SHAMT_W];
  assign o_cout    = w_cout[SHAMT_W];
`endif

  for (genvar k = 0; k < SHAMT_W; k++) begin : gStage
    bsh_stage #(
      .DATA_W (DATA_W),
      .SHAMT_W(SHAMT_W),
      .STEP   (1 << k)
    ) uStage (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_valid(w_valid[k]),
      .o_ready(w_ready[k]),
      .i_data (w_data[k]),
      .i_mode (w_mode[k]),
      .i_shamt(w_shamt[k]),
      .o_valid(w_valid[k+1]),
      .i_ready(w_ready[k+1]),
      .o_data (w_data[k+1]),
      .o_mode (w_mode[k+1]),
      .o_shamt(w_shamt[k+1])
`ifdef BARREL_SHIFTER_FLAG_EN
      ,
      .i_zero (w_zero[k]),
      .i_cout (w_cout[k]),
      .o_zero (w_zero[k+1]),
      .o_cout (w_cout[k+1])
`endif
    );
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (DATA_W=32): directed vector table, backpressure,
// mid-stream reset and a randomised stream, all scored through an expected-result queue.
module tb_barrel_shifter_pipe;
  import bsh_pkg::*;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid;
  logic               o_ready;
  logic [DATA_W-1:0]  i_data;
  logic [SHAMT_W-1:0] i_shamt;
  logic [1:0]         i_mode;
  logic               o_valid;
  logic               i_ready;
  logic [DATA_W-1:0]  o_data;
`ifdef BARREL_SHIFTER_FLAG_EN
  logic               o_zero;
  logic               o_cout;
`endif

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic [31:0] expData;
    logic        expZero;
    logic        expCout;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic        cout;
    int          acceptCyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          checkLat = 1'b0;
  bit          randOn = 1'b0;
  bit          prevStall = 1'b0;
  logic [31:0] heldData;

  barrel_shifter_pipe #(.DATA_W(DATA_W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .i_shamt(i_shamt),
    .i_mode (i_mode),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data)
`ifdef BARREL_SHIFTER_FLAG_EN
    ,
    .o_zero (o_zero),
    .o_cout (o_cout)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t refModel(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m);
    exp_t e;
    int   si;
    si = int'(s);
    e.data = '0;
    for (int i = 0; i < 32; i++) begin
      if (m == 2'b00) begin
        if (i >= si) e.data[i] = d[i-si];
      end else if (m == 2'b01) begin
        if (i + si < 32) e.data[i] = d[i+si];
      end else if (m == 2'b10) begin
        if (i + si < 32) e.data[i] = d[i+si];
        else e.data[i] = d[31];
      end else begin
        e.data[i] = d[(i+si)%32];
      end
    end
    e.zero = (e.data == 32'd0);
    if (si == 0) e.cout = 1'b0;
    else if (m == 2'b00) e.cout = d[32-si];
    else if (m == 2'b11) e.cout = e.data[31];
    else e.cout = d[si-1];
    e.acceptCyc = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m, input exp_t e);
    int waits;
    exp_t ent;
    ent     = e;
    i_valid = 1'b1;
    i_data  = d;
    i_shamt = s;
    i_mode  = m;
    waits   = 0;
    @(negedge clk);
    while (!o_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: o_ready stuck at 0 for %0d cycles, required 1", waits);
    end else begin
      ent.acceptCyc = cyc;
      sb.push_back(ent);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int waits;
    waits = 0;
    while (sb.size() != 0 && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    checkOutput(name, sb.size(), 0);
  endtask

  // Scoreboard: pops one expectation per output handshake and checks the held word during stalls.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("hold_valid", {31'b0, o_valid}, 32'd1);
        checkOutput("hold_data", o_data, heldData);
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_output: got %h with no word outstanding, required none", o_data);
        end else begin
          e = sb.pop_front();
          checkOutput("result", o_data, e.data);
`ifdef BARREL_SHIFTER_FLAG_EN
          checkOutput("zero", {31'b0, o_zero}, {31'b0, e.zero});
          checkOutput("cout", {31'b0, o_cout}, {31'b0, e.cout});
`endif
          if (checkLat) checkOutput("latency", cyc - e.acceptCyc, SHAMT_W);
        end
      end
      prevStall = o_valid && !i_ready;
      heldData  = o_data;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[14];
    exp_t e;
    logic [31:0] d;
    logic [4:0]  s;
    logic [1:0]  m;

    vecs[0]  = '{32'h0000_00F1, 5'd4,  BSH_SLL, 32'h0000_0F10, 1'b0, 1'b0};
    vecs[1]  = '{32'h8000_0000, 5'd31, BSH_SRL, 32'h0000_0001, 1'b0, 1'b0};
    vecs[2]  = '{32'h8000_0010, 5'd4,  BSH_SRA, 32'hF800_0001, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_000F, 5'd4,  BSH_ROR, 32'hF000_0000, 1'b0, 1'b1};
    vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  BSH_SLL, 32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[5]  = '{32'h1234_5678, 5'd0,  BSH_SRL, 32'h1234_5678, 1'b0, 1'b0};
    vecs[6]  = '{32'h8000_0001, 5'd0,  BSH_SRA, 32'h8000_0001, 1'b0, 1'b0};
    vecs[7]  = '{32'hA5A5_A5A5, 5'd0,  BSH_ROR, 32'hA5A5_A5A5, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000_0001, 5'd1,  BSH_SRL, 32'h0000_0000, 1'b1, 1'b1};
    vecs[9]  = '{32'h4000_0000, 5'd2,  BSH_SLL, 32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{32'h7FFF_FFFF, 5'd31, BSH_SRA, 32'h0000_0000, 1'b1, 1'b1};
    vecs[11] = '{32'hFFFF_FFFF, 5'd31, BSH_SLL, 32'h8000_0000, 1'b0, 1'b1};
    vecs[12] = '{32'h8000_0001, 5'd1,  BSH_ROR, 32'hC000_0000, 1'b0, 1'b1};
    vecs[13] = '{32'hF000_0000, 5'd28, BSH_SRA, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    i_shamt = '0;
    i_mode  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_o_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("reset_o_ready", {31'b0, o_ready}, 32'd1);
    checkOutput("reset_o_data", o_data, 32'd0);
`ifdef BARREL_SHIFTER_FLAG_EN
    checkOutput("reset_o_zero", {31'b0, o_zero}, 32'd0);
    checkOutput("reset_o_cout", {31'b0, o_cout}, 32'd0);
`endif

    $display("[TB] directed vectors, back-to-back");
    checkLat = 1'b1;
    for (int i = 0; i < 14; i++) begin
      e.data      = vecs[i].expData;
      e.zero      = vecs[i].expZero;
      e.cout      = vecs[i].expCout;
      e.acceptCyc = 0;
      applyStimulus(vecs[i].data, vecs[i].shamt, vecs[i].mode, e);
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("burst_throughput", sb.size(), 0);
    checkLat = 1'b0;
    waitDrain("directed_drain");

    $display("[TB] backpressure");
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          d = $urandom;
          s = 5'($urandom_range(0, 31));
          m = 2'($urandom_range(0, 3));
          applyStimulus(d, s, m, refModel(d, s, m));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bp_o_ready", {31'b0, o_ready}, 32'd0);
        checkOutput("bp_o_valid", {31'b0, o_valid}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
    join
    waitDrain("bp_drain");

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      applyStimulus(d, 5'd3, BSH_ROR, refModel(d, 5'd3, BSH_ROR));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_o_valid", {31'b0, o_valid}, 32'd0);
    checkOutput("rst_o_data", o_data, 32'd0);
    checkOutput("rst_o_ready", {31'b0, o_ready}, 32'd1);
    checkOutput("rst_flush", sb.size(), 0);
    checkLat = 1'b1;
    applyStimulus(32'h0000_00F1, 5'd4, BSH_SLL, refModel(32'h0000_00F1, 5'd4, BSH_SLL));
    waitDrain("rst_drain");
    repeat (3) @(posedge clk);
    #1;
    checkLat = 1'b0;

    $display("[TB] random stream");
    randOn = 1'b1;
    fork
      begin
        while (randOn) begin
          @(posedge clk);
          #1;
          i_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      m = 2'($urandom_range(0, 3));
      applyStimulus(d, s, m, refModel(d, s, m));
    end
    randOn = 1'b0;
    @(posedge clk);
    #2;
    i_ready = 1'b1;
    waitDrain("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
